alu_seq: RTL and testbench

Small multi-cycle sequencer that sits directly upstream and downstream of the 16-bit ALU (pass/add).
- Accepts 16-bit instructions over a valid/ready handshake.
- Reads operands from an internal 4×16 register file and drives them to the ALU's two data inputs and its 1-bit operation select.
- Captures the ALU result and writes it back into the register file.
- Completes one instruction every 3 cycles; a debug read port exposes register contents.

---
 rtl/alu_seq.sv | 125 ++++++++++++
 tb/tb_alu_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Three-cycle instruction sequencer (IDLE -> EXEC -> WB) around an external combinational 16-bit pass/add ALU.
// Optional carry flag output is enabled by defining ALU_SEQ_CARRY_EN.
module alu_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic        alu_op,
    input  logic [15:0] alu_result,
    output logic        done,
    input  logic [1:0]  dbg_sel,
    output logic [15:0] dbg_data
`ifdef ALU_SEQ_CARRY_EN
    ,
    output logic        carry
`endif
);

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_LDI = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] ir_reg, ir_next;
    logic [15:0] res_reg, res_next;
    logic [15:0] rf_reg [4];
    logic        wr_en;

    logic [3:0]  opcode;
    logic [1:0]  rd, rs1, rs2;
    logic        writes_rd;

    assign opcode    = ir_reg[15:12];
    assign rd        = ir_reg[11:10];
    assign rs1       = ir_reg[9:8];
    assign rs2       = ir_reg[7:6];
    assign writes_rd = (opcode == OP_MOV) || (opcode == OP_ADD) || (opcode == OP_LDI);

    // Operand and debug reads are purely combinational off the register file.
    assign alu_in1  = rf_reg[rs1];
    assign alu_in2  = rf_reg[rs2];
    assign dbg_data = rf_reg[dbg_sel];

    always_comb begin
        state_next  = state_reg;
        ir_next     = ir_reg;
        res_next    = res_reg;
        instr_ready = 1'b0;
        alu_op      = 1'b0;
        done        = 1'b0;
        wr_en       = 1'b0;
        case (state_reg)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_next    = instr;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                alu_op     = (opcode == OP_ADD);
                res_next   = (opcode == OP_LDI) ? {8'h00, ir_reg[7:0]} : alu_result;
                state_next = WB;
            end
            WB: begin
                done       = 1'b1;
                wr_en      = writes_rd;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ir_reg    <= 16'h0000;
            res_reg   <= 16'h0000;
            for (int i = 0; i < 4; i++) begin
                rf_reg[i] <= 16'h0000;
            end
        end else begin
            state_reg <= state_next;
            ir_reg    <= ir_next;
            res_reg   <= res_next;
            if (wr_en) begin
                rf_reg[rd] <= res_reg;
            end
        end
    end

`ifdef ALU_SEQ_CARRY_EN
    // Carry-out is sampled alongside res in EXEC and only committed by an ADD at WB.
    logic [16:0] sum_wide;
    logic        carry_res_reg;
    logic        carry_reg;

    assign sum_wide = {1'b0, alu_in1} + {1'b0, alu_in2};
    assign carry    = carry_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_res_reg <= 1'b0;
            carry_reg     <= 1'b0;
        end else begin
            if (state_reg == EXEC) begin
                carry_res_reg <= sum_wide[16];
            end
            if (state_reg == WB && opcode == OP_ADD) begin
                carry_reg <= carry_res_reg;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes model predictions, a negedge monitor checks EXEC/WB behaviour.
// Carry checks are compiled in when ALU_SEQ_CARRY_EN is defined.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_in1, alu_in2, alu_result, dbg_data;
    logic        alu_op, done;
    logic [1:0]  dbg_sel;
`ifdef ALU_SEQ_CARRY_EN
    logic        carry;
`endif

    always #10 clk = ~clk;

    // Combinational pass/add ALU that the sequencer drives.
    assign alu_result = alu_op ? (alu_in1 + alu_in2) : alu_in1;

    alu_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .done       (done),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
`ifdef ALU_SEQ_CARRY_EN
        ,
        .carry      (carry)
`endif
    );

    typedef struct {
        int               acc;
        logic [15:0]      word;
        bit               is_add;
        logic [15:0]      op1;
        logic [15:0]      op2;
        logic [3:0][15:0] regs;
        bit               cy;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] mregs [4];
    bit          mcarry;
    bit          mon_en = 1'b0;
    int          sweep_req = 0;
    int          sweep_ack = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 6'b000000};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {4'h3, rd, 2'b00, imm};
    endfunction

    // Reference model: architectural effect of one instruction on the register file.
    task automatic model(input logic [15:0] w, input int acc);
        exp_t        e;
        logic [3:0]  op;
        logic [1:0]  rd, rs1, rs2;
        logic [16:0] sum;
        op  = w[15:12];
        rd  = w[11:10];
        rs1 = w[9:8];
        rs2 = w[7:6];
        e.acc    = acc;
        e.word   = w;
        e.is_add = (op == 4'd2);
        e.op1    = mregs[rs1];
        e.op2    = mregs[rs2];
        case (op)
            4'd1: mregs[rd] = e.op1;
            4'd2: begin
                sum       = {1'b0, e.op1} + {1'b0, e.op2};
                mregs[rd] = sum[15:0];
                mcarry    = sum[16];
            end
            4'd3: mregs[rd] = {8'h00, w[7:0]};
            default: ;
        endcase
        for (int i = 0; i < 4; i++) e.regs[i] = mregs[i];
        e.cy = mcarry;
        q.push_back(e);
    endtask

    task automatic send(input logic [15:0] w, output int acc);
        int n;
        bit rdy;
        n = 0;
        rdy = 1'b0;
        instr = w;
        instr_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = instr_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 50);
        chk("accept_timeout", {31'd0, rdy}, 32'd1);
        #1;
        acc = cyc;
        model(w, acc);
    endtask

    task automatic gap(input int n);
        instr_valid = 1'b0;
        instr = 16'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_sweep();
        int n;
        n = 0;
        sweep_req++;
        while (sweep_ack != sweep_req && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("sweep_wait", {31'd0, sweep_ack == sweep_req}, 32'd1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) mregs[i] = 16'h0000;
        mcarry = 1'b0;
        q.delete();
    endtask

    // Monitor: owns dbg_sel, checks EXEC operands and done timing, then register file after each WB.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sweep_req != sweep_ack) begin
                for (int i = 0; i < 4; i++) begin
                    dbg_sel = i[1:0];
                    #1;
                    chk("sweep", {16'd0, dbg_data}, {16'd0, mregs[i]});
                end
                sweep_ack++;
            end
            if (q.size() > 0 && cyc == q[0].acc) begin
                chk("exec_alu_op", {31'd0, alu_op}, {31'd0, q[0].is_add});
                chk("exec_in1", {16'd0, alu_in1}, {16'd0, q[0].op1});
                chk("exec_in2", {16'd0, alu_in2}, {16'd0, q[0].op2});
                chk("exec_ready", {31'd0, instr_ready}, 32'd0);
                chk("exec_done", {31'd0, done}, 32'd0);
            end else if (q.size() > 0 && cyc == q[0].acc + 1) begin
                exp_t e;
                chk("wb_done", {31'd0, done}, 32'd1);
                chk("wb_ready", {31'd0, instr_ready}, 32'd0);
                chk("wb_alu_op", {31'd0, alu_op}, 32'd0);
                e = q.pop_front();
                $display("RETIRE instr=%h accepted_cyc=%0d op1=%h op2=%h", e.word, e.acc, e.op1, e.op2);
                @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++) begin
                    dbg_sel = i[1:0];
                    #1;
                    chk("wb_reg", {16'd0, dbg_data}, {16'd0, e.regs[i]});
                end
`ifdef ALU_SEQ_CARRY_EN
                chk("wb_carry", {31'd0, carry}, {31'd0, e.cy});
`endif
            end else begin
                chk("idle_done", {31'd0, done}, 32'd0);
                chk("idle_alu_op", {31'd0, alu_op}, 32'd0);
                if (q.size() == 0) chk("idle_ready", {31'd0, instr_ready}, 32'd1);
            end
        end
    end

    initial begin
        int acc, prev;
        logic [3:0] op;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 16'h0000;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in1", {16'd0, alu_in1}, 32'd0);
        chk("rst_in2", {16'd0, alu_in2}, 32'd0);
`ifdef ALU_SEQ_CARRY_EN
        chk("rst_carry", {31'd0, carry}, 32'd0);
`endif
        mon_en = 1'b1;
        do_sweep();
        rst_n = 1'b1;
        gap(1);

        // LDI/LDI/ADD
        send(ldi(2'd1, 8'h34), acc);
        send(ldi(2'd2, 8'h12), acc);
        send(enc(4'd2, 2'd3, 2'd1, 2'd2), acc);
        gap(3);
        chk("r3_sum", {16'd0, mregs[3]}, 32'h0046);

        // Repeated doubling, then MOV
        send(ldi(2'd0, 8'hFF), acc);
        for (int i = 0; i < 8; i++) send(enc(4'd2, 2'd0, 2'd0, 2'd0), acc);
        send(enc(4'd1, 2'd2, 2'd0, 2'd0), acc);
        gap(3);
        chk("r2_mov", {16'd0, mregs[2]}, 32'hFF00);

        // Back-to-back: one accept every 3 cycles
        send(ldi(2'd1, 8'h05), prev);
        for (int i = 0; i < 3; i++) begin
            send(enc(4'd2, 2'd1, 2'd1, 2'd1), acc);
            chk("b2b_spacing", acc - prev, 32'd3);
            prev = acc;
        end
        gap(3);

        // NOP and illegal opcode targeting r1
        send(enc(4'd0, 2'd1, 2'd2, 2'd3), acc);
        send(enc(4'd10, 2'd1, 2'd2, 2'd3), acc);
        gap(3);

        // Carry: doubling 0x00FF nine times wraps on the last step
        send(ldi(2'd1, 8'hFF), acc);
        for (int i = 0; i < 9; i++) send(enc(4'd2, 2'd1, 2'd1, 2'd1), acc);
        send(ldi(2'd2, 8'h01), acc);
        send(enc(4'd2, 2'd3, 2'd2, 2'd2), acc);
        gap(3);

        // Randomized traffic
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 5))
                0: op = 4'd0;
                1: op = 4'd1;
                2, 3: op = 4'd2;
                4: op = 4'd3;
                default: op = 4'($urandom_range(4, 15));
            endcase
            send({op, 12'($urandom)}, acc);
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
        end
        gap(4);

        // Reset during an ADD's EXEC cycle aborts it
        send(ldi(2'd2, 8'h77), acc);
        send(enc(4'd2, 2'd1, 2'd2, 2'd2), acc);
        instr_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_in1", {16'd0, alu_in1}, 32'd0);
`ifdef ALU_SEQ_CARRY_EN
        chk("abort_carry", {31'd0, carry}, 32'd0);
`endif
        do_sweep();

        begin
            int n;
            n = 0;
            while (q.size() > 0 && n < 20) begin
                @(posedge clk);
                n++;
            end
        end
        chk("drain", q.size(), 32'd0);
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
